// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic matrix-multiply tile.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) r++;
    return r;
  endfunction

  // Smallest accumulator that cannot wrap for kmax full-scale products.
  function automatic int unsigned acc_bits_min(input int unsigned dbits, input int unsigned kmax);
    return 2 * dbits + clog2(kmax);
  endfunction

  localparam int unsigned ACCBITS_MIN_DEFAULT = acc_bits_min(8, 256);

endpackage

// File: rtl/systolic_mac_pe.sv
// One processing element: registers A east and B south, accumulates A*B when both operands are valid.
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DBITS   = 8,
  parameter int unsigned ACCBITS = 24,
  parameter bit          SIGNED  = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic [DBITS-1:0]   i_a,
  input  logic               i_a_vld,
  input  logic [DBITS-1:0]   i_b,
  input  logic               i_b_vld,
  output logic [DBITS-1:0]   o_a,
  output logic               o_a_vld,
  output logic [DBITS-1:0]   o_b,
  output logic               o_b_vld,
  output logic [ACCBITS-1:0] o_acc
);

  localparam int unsigned PW = 2 * DBITS;

  logic [PW-1:0]      w_a_ext;
  logic [PW-1:0]      w_b_ext;
  logic [PW-1:0]      w_prod;
  logic [ACCBITS-1:0] w_prod_ext;

  logic [DBITS-1:0]   r_a;
  logic               r_a_vld;
  logic [DBITS-1:0]   r_b;
  logic               r_b_vld;
  logic [ACCBITS-1:0] r_acc;

  // Operands widened to the full product width so the low PW bits are exact in either mode.
  always_comb begin
    if (SIGNED) begin
      w_a_ext = PW'($signed(i_a));
      w_b_ext = PW'($signed(i_b));
    end else begin
      w_a_ext = PW'(i_a);
      w_b_ext = PW'(i_b);
    end
    w_prod     = w_a_ext * w_b_ext;
    w_prod_ext = SIGNED ? ACCBITS'($signed(w_prod)) : ACCBITS'(w_prod);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_a     <= '0;
      r_a_vld <= 1'b0;
      r_b     <= '0;
      r_b_vld <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_a     <= i_a;
      r_a_vld <= i_a_vld;
      r_b     <= i_b;
      r_b_vld <= i_b_vld;
      if (i_a_vld && i_b_vld) r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_a     = r_a;
  assign o_a_vld = r_a_vld;
  assign o_b     = r_b;
  assign o_b_vld = r_b_vld;
  assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_mm_tile.sv
// ROWSxCOLS output-stationary systolic tile: skewed operand feed over K beats, flush, row-by-row drain.
module systolic_mm_tile
  import systolic_pkg::*;
#(
  parameter int unsigned DBITS   = 8,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned KMAX    = 256,
  parameter int unsigned ACCBITS = 24,
  parameter bit          SIGNED  = 1'b1
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic                      i_START,
  input  logic [clog2(KMAX+1)-1:0]  i_CFG_K,
  output logic                      o_BUSY,
  input  logic [ROWS*DBITS-1:0]     i_A,
  input  logic [COLS*DBITS-1:0]     i_B,
  input  logic                      i_IN_VALID,
  output logic                      o_IN_READY,
  output logic [COLS*ACCBITS-1:0]   o_OUT_DATA,
  output logic [clog2(ROWS)-1:0]    o_OUT_ROW,
  output logic                      o_OUT_LAST,
  output logic                      o_OUT_VALID,
  input  logic                      i_OUT_READY,
  output logic                      o_DONE
);

  localparam int unsigned KW = clog2(KMAX + 1);
  localparam int unsigned RW = clog2(ROWS);
  localparam int unsigned FW = clog2(ROWS + COLS);

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [KW-1:0] r_beat, w_beat_nxt;
  logic [FW-1:0] r_flush, w_flush_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic          w_clear;
  logic          w_done_nxt;
  logic          w_in_acc;
  logic          w_pe_clr;

  logic r_busy, r_in_ready, r_out_valid, r_out_last, r_done;

  logic [DBITS-1:0]   w_a   [ROWS][COLS+1];
  logic               w_av  [ROWS][COLS+1];
  logic [DBITS-1:0]   w_b   [ROWS+1][COLS];
  logic               w_bv  [ROWS+1][COLS];
  logic [ACCBITS-1:0] w_acc [ROWS][COLS];
  logic               w_unused;

  assign w_in_acc = i_IN_VALID & r_in_ready;
  assign w_pe_clr = i_RST | w_clear;

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_beat_nxt  = r_beat;
    w_flush_nxt = r_flush;
    w_row_nxt   = r_row;
    w_clear     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_START && (i_CFG_K != '0)) begin
          w_state_nxt = ST_FEED;
          w_k_nxt     = i_CFG_K;
          w_beat_nxt  = '0;
          w_clear     = 1'b1;
        end
      end
      ST_FEED: begin
        if (w_in_acc) begin
          w_beat_nxt = r_beat + KW'(1);
          if (w_beat_nxt == r_k) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (r_flush == FW'(ROWS + COLS - 2)) begin
          w_state_nxt = ST_DRAIN;
          w_row_nxt   = '0;
        end else begin
          w_flush_nxt = r_flush + FW'(1);
        end
      end
      ST_DRAIN: begin
        if (i_OUT_READY) begin
          if (r_row == RW'(ROWS - 1)) begin
            w_state_nxt = ST_IDLE;
            w_row_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_beat      <= '0;
      r_flush     <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_beat      <= w_beat_nxt;
      r_flush     <= w_flush_nxt;
      r_row       <= w_row_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_in_ready  <= (w_state_nxt == ST_FEED);
      r_out_valid <= (w_state_nxt == ST_DRAIN);
      r_out_last  <= (w_state_nxt == ST_DRAIN) && (w_row_nxt == RW'(ROWS - 1));
      r_done      <= w_done_nxt;
    end
  end

  // Input skew: lane n sits behind n extra register stages so operands meet on the diagonal.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [DBITS-1:0] r_sh [r+1];
    logic [r:0]       r_vsh;
    always_ff @(posedge i_CLK) begin
      if (w_pe_clr) begin
        r_vsh <= '0;
        for (int j = 0; j <= r; j++) r_sh[j] <= '0;
      end else begin
        r_sh[0]  <= i_A[r*DBITS +: DBITS];
        r_vsh[0] <= w_in_acc;
        for (int j = 1; j <= r; j++) begin
          r_sh[j]  <= r_sh[j-1];
          r_vsh[j] <= r_vsh[j-1];
        end
      end
    end
    assign w_a[r][0]  = r_sh[r];
    assign w_av[r][0] = r_vsh[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic [DBITS-1:0] r_sh [c+1];
    logic [c:0]       r_vsh;
    always_ff @(posedge i_CLK) begin
      if (w_pe_clr) begin
        r_vsh <= '0;
        for (int j = 0; j <= c; j++) r_sh[j] <= '0;
      end else begin
        r_sh[0]  <= i_B[c*DBITS +: DBITS];
        r_vsh[0] <= w_in_acc;
        for (int j = 1; j <= c; j++) begin
          r_sh[j]  <= r_sh[j-1];
          r_vsh[j] <= r_vsh[j-1];
        end
      end
    end
    assign w_b[0][c]  = r_sh[c];
    assign w_bv[0][c] = r_vsh[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_mac_pe #(
        .DBITS  (DBITS),
        .ACCBITS(ACCBITS),
        .SIGNED (SIGNED)
      ) u_pe (
        .i_clk  (i_CLK),
        .i_clr  (w_pe_clr),
        .i_a    (w_a[r][c]),
        .i_a_vld(w_av[r][c]),
        .i_b    (w_b[r][c]),
        .i_b_vld(w_bv[r][c]),
        .o_a    (w_a[r][c+1]),
        .o_a_vld(w_av[r][c+1]),
        .o_b    (w_b[r+1][c]),
        .o_b_vld(w_bv[r+1][c]),
        .o_acc  (w_acc[r][c])
      );
    end
  end

  // Operands leaving the east and south edges have no consumer.
  always_comb begin
    w_unused = 1'b0;
    for (int r = 0; r < ROWS; r++) w_unused = w_unused ^ (^w_a[r][COLS]) ^ w_av[r][COLS];
    for (int c = 0; c < COLS; c++) w_unused = w_unused ^ (^w_b[ROWS][c]) ^ w_bv[ROWS][c];
  end

  // Accumulators are frozen during DRAIN, so the row read is stable while the consumer stalls.
  always_comb begin
    o_OUT_DATA = '0;
    for (int c = 0; c < COLS; c++) o_OUT_DATA[c*ACCBITS +: ACCBITS] = w_acc[r_row][c];
  end

  assign o_BUSY      = r_busy;
  assign o_IN_READY  = r_in_ready;
  assign o_OUT_ROW   = r_row;
  assign o_OUT_LAST  = r_out_last;
  assign o_OUT_VALID = r_out_valid;
  assign o_DONE      = r_done;

endmodule

// File: tb/tb_systolic_mm_tile.sv
// Directed bench: 2x2 unsigned tile driven from a vector table, plus a 4x4 signed tile.
module tb_systolic_mm_tile;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        s2_start, s2_busy, s2_iv, s2_ir, s2_last, s2_ov, s2_or, s2_done;
  logic [8:0]  s2_k;
  logic [15:0] s2_a, s2_b;
  logic [47:0] s2_od;
  logic [0:0]  s2_row;

  logic        s4_start, s4_busy, s4_iv, s4_ir, s4_last, s4_ov, s4_or, s4_done;
  logic [8:0]  s4_k;
  logic [31:0] s4_a, s4_b;
  logic [95:0] s4_od;
  logic [1:0]  s4_row;

  systolic_mm_tile #(.DBITS(8), .ROWS(2), .COLS(2), .KMAX(256), .ACCBITS(24), .SIGNED(1'b0)) u2 (
    .i_CLK(clk), .i_RST(rst), .i_START(s2_start), .i_CFG_K(s2_k), .o_BUSY(s2_busy),
    .i_A(s2_a), .i_B(s2_b), .i_IN_VALID(s2_iv), .o_IN_READY(s2_ir),
    .o_OUT_DATA(s2_od), .o_OUT_ROW(s2_row), .o_OUT_LAST(s2_last), .o_OUT_VALID(s2_ov),
    .i_OUT_READY(s2_or), .o_DONE(s2_done));

  systolic_mm_tile #(.DBITS(8), .ROWS(4), .COLS(4), .KMAX(256), .ACCBITS(24), .SIGNED(1'b1)) u4 (
    .i_CLK(clk), .i_RST(rst), .i_START(s4_start), .i_CFG_K(s4_k), .o_BUSY(s4_busy),
    .i_A(s4_a), .i_B(s4_b), .i_IN_VALID(s4_iv), .o_IN_READY(s4_ir),
    .o_OUT_DATA(s4_od), .o_OUT_ROW(s4_row), .o_OUT_LAST(s4_last), .o_OUT_VALID(s4_ov),
    .i_OUT_READY(s4_or), .o_DONE(s4_done));

  typedef struct packed {
    logic [1:0][1:0][7:0]  a;     // [k][r]
    logic [1:0][1:0][7:0]  b;     // [k][c]
    logic                  bubble;
    logic [3:0]            stall;
    logic [1:0][1:0][23:0] expv;  // [r][c]
  } vec_t;

  vec_t        vecs [5];
  logic [7:0]  g_a   [256][2];
  logic [7:0]  g_b   [256][2];
  logic [23:0] g_exp [2][2];
  int          g_id;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (job %0d): got %0h, expected %0h", nm, g_id, act, exp);
    end
  endtask

  task automatic run2(input int k, input bit bubble, input int stall, input bit poke);
    int idx, cyc, fcyc, fl, tot;
    bit rdy, stable;
    logic [47:0] hold_d;
    logic [0:0]  hold_r;
    s2_k = 9'(k);
    s2_start = 1'b1;
    tick(); tot = 1;
    s2_start = poke;
    s2_k = 9'd1;
    chk("start_busy", 64'(s2_busy), 64'd1);
    chk("start_in_ready", 64'(s2_ir), 64'd1);
    idx = 0; cyc = 0; fcyc = 0;
    while (idx < k && cyc < 4 * k + 10) begin
      rdy   = s2_ir;
      s2_iv = bubble ? ((cyc % 2) == 1) : 1'b1;
      s2_a  = {g_a[idx][1], g_a[idx][0]};
      s2_b  = {g_b[idx][1], g_b[idx][0]};
      tick(); tot++; cyc++;
      if (rdy) fcyc++;
      if (s2_iv && rdy) idx++;
    end
    s2_iv = 1'b0;
    s2_start = 1'b0;
    chk("feed_beats", 64'(idx), 64'(k));
    chk("feed_cycles", 64'(fcyc), bubble ? 64'(2 * k) : 64'(k));
    fl = 0;
    while (!s2_ov && fl < 20) begin
      tick(); tot++; fl++;
    end
    chk("flush_cycles", 64'(fl), 64'd3);
    for (int row = 0; row < 2; row++) begin
      if (row == 0 && stall > 0) begin
        s2_or = 1'b0;
        hold_d = s2_od; hold_r = s2_row; stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
          if (poke) s2_start = 1'b1;
          tick(); tot++;
          if (s2_od !== hold_d || s2_row !== hold_r || s2_ov !== 1'b1) stable = 1'b0;
        end
        s2_start = 1'b0;
        chk("stall_stable", 64'(stable), 64'd1);
      end
      s2_or = 1'b1;
      chk("out_valid", 64'(s2_ov), 64'd1);
      chk("out_row", 64'(s2_row), 64'(row));
      chk("out_last", 64'(s2_last), 64'(row == 1));
      chk("no_early_done", 64'(s2_done), 64'd0);
      for (int c = 0; c < 2; c++) chk("out_lane", 64'(s2_od[c*24 +: 24]), 64'(g_exp[row][c]));
      tick(); tot++;
    end
    s2_or = 1'b0;
    chk("done_pulse", 64'(s2_done), 64'd1);
    chk("idle_after_done", 64'(s2_busy), 64'd0);
    chk("job_cycles", 64'(tot), 64'(1 + (bubble ? 2 * k : k) + 3 + 2 + stall));
    tick();
    chk("done_once", 64'(s2_done), 64'd0);
  endtask

  task automatic load_vec(input vec_t v);
    for (int kk = 0; kk < 2; kk++)
      for (int l = 0; l < 2; l++) begin
        g_a[kk][l]   = v.a[kk][l];
        g_b[kk][l]   = v.b[kk][l];
        g_exp[kk][l] = v.expv[kk][l];
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    int beats, wt;
    vecs[0] = '{a: {8'd4, 8'd2, 8'd3, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, bubble: 1'b0, stall: 4'd0,
                expv: {24'd50, 24'd43, 24'd22, 24'd19}};
    vecs[1] = vecs[0]; vecs[1].bubble = 1'b1;
    vecs[2] = vecs[0]; vecs[2].stall = 4'd5;
    vecs[3] = '{a: {4{8'hFF}}, b: {4{8'hFF}}, bubble: 1'b0, stall: 4'd0, expv: {4{24'd130050}}};
    vecs[4] = '{a: {8'd0, 8'd2, 8'd1, 8'd0}, b: {8'd3, 8'd0, 8'd0, 8'd9}, bubble: 1'b1, stall: 4'd1,
                expv: {24'd0, 24'd9, 24'd6, 24'd0}};

    rst = 1'b1;
    s2_start = 0; s2_k = 0; s2_a = 0; s2_b = 0; s2_iv = 0; s2_or = 0;
    s4_start = 0; s4_k = 0; s4_a = 0; s4_b = 0; s4_iv = 0; s4_or = 0;
    g_id = -1;
    tick(); tick();
    chk("reset_u2", 64'({s2_busy, s2_ir, s2_ov, s2_last, s2_done, s2_row, s2_od}), 64'd0);
    chk("reset_u4_ctl", 64'({s4_busy, s4_ir, s4_ov, s4_last, s4_done, s4_row}), 64'd0);
    chk("reset_u4_data", s4_od[63:0] | 64'(s4_od[95:64]), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      g_id = i;
      load_vec(vecs[i]);
      run2(2, vecs[i].bubble, int'(vecs[i].stall), 1'b0);
    end

    // Abandon a job mid-feed, then rerun the reference case.
    g_id = 10;
    s2_k = 9'd2; s2_start = 1'b1;
    tick();
    s2_start = 1'b0; s2_iv = 1'b1; s2_a = 16'h0909; s2_b = 16'h0909;
    tick();
    s2_iv = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("after_reset", 64'({s2_busy, s2_ir, s2_ov, s2_last, s2_done, s2_row, s2_od}), 64'd0);
    load_vec(vecs[0]);
    run2(2, 1'b0, 0, 1'b0);

    // A zero inner dimension never starts a job.
    g_id = 11;
    s2_k = 9'd0; s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    chk("k0_busy", 64'(s2_busy), 64'd0);
    chk("k0_in_ready", 64'(s2_ir), 64'd0);
    tick();
    chk("k0_still_idle", 64'(s2_busy), 64'd0);

    // Full-scale K with start poked while busy.
    g_id = 12;
    for (int kk = 0; kk < 256; kk++) begin
      g_a[kk][0] = 8'hFF; g_a[kk][1] = 8'hFF; g_b[kk][0] = 8'hFF; g_b[kk][1] = 8'hFF;
    end
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) g_exp[r][c] = 24'd16646400;
    run2(256, 1'b0, 2, 1'b1);

    // Signed 4x4, K=3: (-1)*2 accumulated three times.
    g_id = 20;
    s4_k = 9'd3; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    s4_a = {4{8'hFF}}; s4_b = {4{8'h02}};
    beats = 0; wt = 0;
    while (beats < 3 && wt < 20) begin
      s4_iv = 1'b1;
      if (s4_ir) beats++;
      tick(); wt++;
    end
    s4_iv = 1'b0;
    chk("s4_beats", 64'(beats), 64'd3);
    wt = 0;
    while (!s4_ov && wt < 20) begin
      tick(); wt++;
    end
    chk("s4_flush_cycles", 64'(wt), 64'd7);
    for (int row = 0; row < 4; row++) begin
      s4_or = 1'b1;
      chk("s4_valid", 64'(s4_ov), 64'd1);
      chk("s4_row", 64'(s4_row), 64'(row));
      chk("s4_last", 64'(s4_last), 64'(row == 3));
      for (int c = 0; c < 4; c++) chk("s4_lane", 64'(s4_od[c*24 +: 24]), 64'h0000_0000_00FF_FFFA);
      tick();
    end
    s4_or = 1'b0;
    chk("s4_done", 64'(s4_done), 64'd1);
    tick();
    chk("s4_done_once", 64'(s4_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
